// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP word, default reset PC, decode field positions.
// The HOLD state exists only when FETCH_HOLD_BUF_EN is defined.
package cpu_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1
`ifdef FETCH_HOLD_BUF_EN
        , F_HOLD = 2'd2
`endif
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC buffer that parks a fetch response while IF/ID is stalled.
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            instr_q <= NOP;
            pc_q    <= 32'h0;
        end else if (i_wr) begin
            instr_q <= i_instr;
            pc_q    <= i_pc;
        end
    end

    assign o_instr = instr_q;
    assign o_pc    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: REQ/WAIT(/HOLD) FSM driving the imem bus and the IF/ID register.
// Define FETCH_HOLD_BUF_EN to park responses that arrive while IF/ID is stalled.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fetch_stage_if.master        imem,
    input  logic                 i_stall,
    input  logic                 i_redirect,
    input  logic [31:0]          i_redirect_pc,
    output logic                 o_valid,
    output logic [31:0]          o_instr,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_pc_plus4,
    output logic [5:0]           o_opcode,
    output logic [5:0]           o_funct
);
    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         discard_q;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_pc4_q;

    logic         ifid_free;
    logic         req;
    logic         acc;
    logic [31:0]  redir_pc;
    logic         ld_en;
    logic [31:0]  ld_instr;
    logic [31:0]  ld_pc;

    assign ifid_free = !valid_q || !i_stall;
    assign redir_pc  = align_pc(i_redirect_pc);

`ifdef FETCH_HOLD_BUF_EN
    logic        hb_wr;
    logic        hb_clr;
    logic [31:0] hb_instr;
    logic [31:0] hb_pc;

    assign req    = (state_q == F_REQ) && !i_rst;
    assign hb_wr  = (state_q == F_WAIT) && imem.i_imem_rvalid && !i_redirect
                    && !discard_q && !ifid_free;
    assign hb_clr = (state_q == F_HOLD) && (i_redirect || !i_stall);

    fetch_hold_buf u_hold_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (hb_wr),
        .i_clr   (hb_clr),
        .i_instr (imem.i_imem_rdata),
        .i_pc    (pc_q),
        .o_instr (hb_instr),
        .o_pc    (hb_pc)
    );
`else
    // No place to park a response, so do not ask for one the stalled IF/ID cannot take.
    assign req = (state_q == F_REQ) && !i_rst && ifid_free;
`endif

    assign acc = req && imem.i_imem_gnt;

    always_comb begin
        ld_en    = 1'b0;
        ld_instr = imem.i_imem_rdata;
        ld_pc    = pc_q;
        case (state_q)
            F_WAIT: ld_en = imem.i_imem_rvalid && !i_redirect && !discard_q && ifid_free;
`ifdef FETCH_HOLD_BUF_EN
            F_HOLD: begin
                ld_en    = !i_redirect && !i_stall;
                ld_instr = hb_instr;
                ld_pc    = hb_pc;
            end
`endif
            default: ld_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= F_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= NOP;
            if_pc_q   <= 32'h0;
            if_pc4_q  <= 32'h0;
        end else begin
            // IF/ID register: redirect beats stall, stall freezes, otherwise drain.
            if (i_redirect) begin
                valid_q <= 1'b0;
            end else if (ld_en) begin
                valid_q  <= 1'b1;
                instr_q  <= ld_instr;
                if_pc_q  <= ld_pc;
                if_pc4_q <= ld_pc + 32'd4;
            end else if (!i_stall) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                F_REQ: begin
                    if (i_redirect) pc_q <= redir_pc;
                    if (acc) begin
                        state_q   <= F_WAIT;
                        discard_q <= i_redirect;
                    end
                end
                F_WAIT: begin
                    if (i_redirect) begin
                        pc_q <= redir_pc;
                        if (imem.i_imem_rvalid) begin
                            discard_q <= 1'b0;
                            state_q   <= F_REQ;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end else if (imem.i_imem_rvalid) begin
                        discard_q <= 1'b0;
                        state_q   <= F_REQ;
                        if (ld_en) pc_q <= pc_q + 32'd4;
`ifdef FETCH_HOLD_BUF_EN
                        if (!discard_q && !ifid_free) state_q <= F_HOLD;
`endif
                    end
                end
`ifdef FETCH_HOLD_BUF_EN
                F_HOLD: begin
                    if (i_redirect) begin
                        pc_q    <= redir_pc;
                        state_q <= F_REQ;
                    end else if (!i_stall) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= F_REQ;
                    end
                end
`endif
                default: state_q <= F_REQ;
            endcase
        end
    end

    assign imem.o_imem_req  = req;
    assign imem.o_imem_addr = pc_q;
    assign o_valid          = valid_q;
    assign o_instr          = instr_q;
    assign o_pc             = if_pc_q;
    assign o_pc_plus4       = if_pc4_q;
    assign o_opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign o_funct          = instr_q[FUNCT_MSB:FUNCT_LSB];
endmodule
